// File: rtl/debounce_fsm.sv
// Switch debouncer: synchronizes noisy_in, qualifies each level change against an external timer,
// and emits one-cycle edge pulses. Define DEBOUNCE_GLITCH_CNT_EN to add a saturating abort counter.
module debounce_fsm #(
  parameter int SYNC_STAGES = 2,
  parameter bit INIT_LEVEL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       noisy_in,
  input  logic       timer_done,
  output logic       timer_en,
  output logic       debounced_out,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [7:0] glitch_cnt
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam state_t RESET_STATE = INIT_LEVEL ? STABLE_HI : STABLE_LO;

  function automatic logic is_wait(input state_t s);
    return (s == WAIT_HI) || (s == WAIT_LO);
  endfunction

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   sync_in;
  state_t                 state;
  state_t                 state_nxt;
  logic                   armed;
  logic                   qual_done;

  // synchronizer stage boundary: only the last flop feeds the FSM
  always_ff @(posedge clk) begin
    if (!rst_n) sync_p <= {SYNC_STAGES{INIT_LEVEL}};
    else        sync_p <= {sync_p[SYNC_STAGES-2:0], noisy_in};
  end

  assign sync_in = sync_p[SYNC_STAGES-1];

  // armed is clear during the first WAIT cycle, so a done level left over from a previous run is ignored
  assign qual_done = timer_done && armed;

  always_comb begin
    state_nxt = state;
    case (state)
      STABLE_LO: if (sync_in) state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (!sync_in)       state_nxt = STABLE_LO;
        else if (qual_done) state_nxt = STABLE_HI;
      end
      STABLE_HI: if (!sync_in) state_nxt = WAIT_LO;
      WAIT_LO: begin
        if (sync_in)        state_nxt = STABLE_HI;
        else if (qual_done) state_nxt = STABLE_LO;
      end
      default: state_nxt = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RESET_STATE;
    else        state <= state_nxt;
  end

  // output stage boundary: every output is registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed         <= 1'b0;
      timer_en      <= 1'b0;
      debounced_out <= INIT_LEVEL;
      rise_pulse    <= 1'b0;
      fall_pulse    <= 1'b0;
    end else begin
      armed         <= is_wait(state) && (state_nxt == state);
      timer_en      <= is_wait(state_nxt);
      debounced_out <= (state_nxt == STABLE_HI) || (state_nxt == WAIT_LO);
      rise_pulse    <= (state == WAIT_HI) && (state_nxt == STABLE_HI);
      fall_pulse    <= (state == WAIT_LO) && (state_nxt == STABLE_LO);
    end
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       abort;
  logic [7:0] glitch_q;

  assign abort = ((state == WAIT_HI) && !sync_in) || ((state == WAIT_LO) && sync_in);

  always_ff @(posedge clk) begin
    if (!rst_n)     glitch_q <= 8'd0;
    else if (abort) glitch_q <= sat_inc(glitch_q);
  end

  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_debounce_fsm.sv
// Directed bench for debounce_fsm: a timer model drives timer_done, expected pulses are queued at
// stimulus time and matched by a negedge monitor; level/count checks are made inline.
module tb_debounce_fsm;

  localparam int SYNC = 2;
  localparam int QUAL = 100;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif
  localparam logic [1:0] RISE = 2'b10;
  localparam logic [1:0] FALL = 2'b01;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       noisy_in = 1'b0;
  logic       timer_done;
  logic       timer_en;
  logic       debounced_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] glitch_cnt;

  logic       done_force = 1'b0;
  int         tcnt = 0;
  int         n_vec = 0;
  int         n_err = 0;
  logic [1:0] sb_q[$];

  debounce_fsm #(.SYNC_STAGES(SYNC), .INIT_LEVEL(1'b0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .noisy_in     (noisy_in),
    .timer_done   (timer_done),
    .timer_en     (timer_en),
    .debounced_out(debounced_out),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .glitch_cnt   (glitch_cnt)
  );

  always #5 clk = ~clk;

  // Timer model: counts enabled cycles, done once QUAL of them have elapsed
  always @(posedge clk) tcnt <= timer_en ? tcnt + 1 : 0;
  assign timer_done = done_force || (timer_en && (tcnt >= QUAL));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_en(input logic lvl, input int budget, output int cyc);
    cyc = 0;
    while (timer_en !== lvl && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Pulse scoreboard: every pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rise_pulse || fall_pulse) begin
      if (sb_q.size() == 0) check("unexpected_pulse", 32'({rise_pulse, fall_pulse}), 32'd0);
      else                  check("pulse_kind", 32'({rise_pulse, fall_pulse}), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    int cyc;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_timer_en", 32'(timer_en), 32'd0);
    check("rst_deb", 32'(debounced_out), 32'd0);
    check("rst_rise", 32'(rise_pulse), 32'd0);
    check("rst_fall", 32'(fall_pulse), 32'd0);
    check("rst_glitch", 32'(glitch_cnt), 32'd0);

    // clean rise
    noisy_in = 1'b1;
    sb_q.push_back(RISE);
    wait_en(1'b1, 20, cyc);
    check("rise_latency", 32'(cyc), 32'(SYNC + 1));
    check("rise_wait_deb", 32'(debounced_out), 32'd0);
    wait_en(1'b0, 200, cyc);
    check("rise_qual_len", 32'(cyc), 32'(QUAL + 1));
    check("rise_deb", 32'(debounced_out), 32'd1);
    check("rise_pulse_on", 32'(rise_pulse), 32'd1);
    @(negedge clk);
    check("rise_pulse_off", 32'(rise_pulse), 32'd0);
    check("rise_en_low", 32'(timer_en), 32'd0);

    // stale done held high before WAIT_LO entry
    done_force = 1'b1;
    noisy_in = 1'b0;
    sb_q.push_back(FALL);
    wait_en(1'b1, 20, cyc);
    check("stale_latency", 32'(cyc), 32'(SYNC + 1));
    check("stale_entry_deb", 32'(debounced_out), 32'd1);
    @(negedge clk);
    check("stale_first_en", 32'(timer_en), 32'd1);
    check("stale_first_deb", 32'(debounced_out), 32'd1);
    @(negedge clk);
    check("stale_second_en", 32'(timer_en), 32'd0);
    check("stale_second_deb", 32'(debounced_out), 32'd0);
    check("stale_fall", 32'(fall_pulse), 32'd1);
    done_force = 1'b0;
    @(negedge clk);

    // bounce: four 3-cycle high excursions, then hold high
    sb_q.push_back(RISE);
    for (int i = 0; i < 4; i++) begin
      noisy_in = 1'b1;
      repeat (3) @(negedge clk);
      noisy_in = 1'b0;
      repeat (3) @(negedge clk);
    end
    check("bounce_deb", 32'(debounced_out), 32'd0);
    check("bounce_glitch", 32'(glitch_cnt), GC ? 32'd4 : 32'd0);
    noisy_in = 1'b1;
    wait_en(1'b1, 20, cyc);
    wait_en(1'b0, 200, cyc);
    check("bounce_qual_len", 32'(cyc), 32'(QUAL + 1));
    check("bounce_deb_final", 32'(debounced_out), 32'd1);

    // clean fall
    sb_q.push_back(FALL);
    noisy_in = 1'b0;
    wait_en(1'b1, 20, cyc);
    wait_en(1'b0, 200, cyc);
    check("fall_qual_len", 32'(cyc), 32'(QUAL + 1));
    check("fall_deb", 32'(debounced_out), 32'd0);

    // abort and qualified done in the same WAIT_HI cycle
    noisy_in = 1'b1;
    wait_en(1'b1, 20, cyc);
    check("simul_enter", 32'(timer_en), 32'd1);
    repeat (5) @(negedge clk);
    noisy_in = 1'b0;
    repeat (2) @(negedge clk);
    done_force = 1'b1;
    @(negedge clk);
    done_force = 1'b0;
    check("simul_en", 32'(timer_en), 32'd0);
    check("simul_deb", 32'(debounced_out), 32'd0);
    check("simul_rise", 32'(rise_pulse), 32'd0);
    check("simul_glitch", 32'(glitch_cnt), GC ? 32'd5 : 32'd0);

    // reset during cycle 50 of WAIT_HI
    noisy_in = 1'b1;
    wait_en(1'b1, 20, cyc);
    repeat (49) @(negedge clk);
    check("rstmid_before_en", 32'(timer_en), 32'd1);
    rst_n = 1'b0;
    noisy_in = 1'b0;
    @(negedge clk);
    check("rstmid_en", 32'(timer_en), 32'd0);
    check("rstmid_deb", 32'(debounced_out), 32'd0);
    check("rstmid_rise", 32'(rise_pulse), 32'd0);
    check("rstmid_glitch", 32'(glitch_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_en", 32'(timer_en), 32'd0);
    check("release_deb", 32'(debounced_out), 32'd0);
    check("release_glitch", 32'(glitch_cnt), 32'd0);

    // 300 aborts: counter saturates at 255
    for (int i = 1; i <= 300; i++) begin
      noisy_in = 1'b1;
      repeat (3) @(negedge clk);
      noisy_in = 1'b0;
      repeat (3) @(negedge clk);
      if (i == 254 || i == 255 || i == 300)
        check($sformatf("sat_%0d", i), 32'(glitch_cnt), GC ? 32'((i < 255) ? i : 255) : 32'd0);
    end
    check("sat_deb", 32'(debounced_out), 32'd0);

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
